// File: rtl/div_mod_serial.sv
// div_mod_serial: bit-serial remainder / divisibility checker.
// The operand is shifted in MSB-first, one bit per clock. A running remainder
// tracks (prefix of number) mod divisor, so a WIDTH-bit operand finishes in
// WIDTH RUN cycles with a single DIV_W+1 bit compare/subtract per cycle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; the
// result outputs are held stable for as long as out_valid is high, and a
// result is not consumed in the same cycle a new operand is accepted.
module div_mod_serial #(
  parameter int WIDTH = 16,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] number,
  input  logic [DIV_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIV_W-1:0] remainder,
  output logic             is_div,
  output logic             div_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] sh;
  logic [DIV_W-1:0] d;
  logic [DIV_W-1:0] rem;
  logic [CNT_W-1:0] cnt;

  logic [DIV_W-1:0] remainder_q;
  logic             is_div_q;
  logic             div_err_q;

  logic             accept;
  logic             last_step;
  logic [DIV_W:0]   t;
  logic [DIV_W:0]   diff;
  logic [DIV_W-1:0] rem_next;

  assign accept    = in_valid & in_ready;
  assign last_step = (cnt == '0);

  // One restoring-division step: rem < d keeps t < 2d, so one subtract is enough.
  always_comb begin
    t        = {rem, sh[WIDTH-1]};
    diff     = t - {1'b0, d};
    rem_next = t[DIV_W-1:0];
    if (t >= {1'b0, d}) begin
      rem_next = diff[DIV_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a zero divisor skips RUN and reports an error at once.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded purely from state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      RUN:     busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath: operand capture, serial remainder update and result registers.
  // Result registers only load on entry to DONE so they hold in IDLE and RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh          <= '0;
      d           <= '0;
      rem         <= '0;
      cnt         <= '0;
      remainder_q <= '0;
      is_div_q    <= 1'b0;
      div_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sh  <= number;
            d   <= divisor;
            rem <= '0;
            cnt <= CNT_W'(WIDTH - 1);
            if (divisor == '0) begin
              remainder_q <= '0;
              is_div_q    <= 1'b0;
              div_err_q   <= 1'b1;
            end
          end
        end
        RUN: begin
          sh  <= {sh[WIDTH-2:0], 1'b0};
          rem <= rem_next;
          if (last_step) begin
            remainder_q <= rem_next;
            is_div_q    <= (rem_next == '0);
            div_err_q   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign remainder = remainder_q;
  assign is_div    = is_div_q;
  assign div_err   = div_err_q;

endmodule
